// File: rtl/pipe_elastic_if.sv
// Handshake bundle for pipe_elastic: producer side, consumer side, flush and occupancy.
// The pipeline takes the slave modport; the driving environment takes master.
interface pipe_elastic_if #(
    parameter int width_p = 8,
    parameter int depth_p = 3
);
    localparam int cnt_w_lp = $clog2(depth_p + 1);

    logic               valid_i;
    logic [width_p-1:0] data_i;
    logic               ready_o;
    logic               valid_o;
    logic [width_p-1:0] data_o;
    logic               ready_i;
    logic               flush_i;
    logic [cnt_w_lp-1:0] count_o;

    modport slave (
        input  valid_i, data_i, ready_i, flush_i,
        output ready_o, valid_o, data_o, count_o
    );

    modport master (
        output valid_i, data_i, ready_i, flush_i,
        input  ready_o, valid_o, data_o, count_o
    );
endinterface

// File: rtl/pipe_elastic.sv
// Elastic valid/ready delay line of depth_p registered stages with collapsing bubbles,
// synchronous flush and a registered occupancy count.
module pipe_elastic_stage #(
    parameter int width_p = 8
) (
    input  logic               clk_i,
    input  logic               reset_ni,
    input  logic               flush_i,
    input  logic               adv_i,
    input  logic               vld_i,
    input  logic [width_p-1:0] data_i,
    output logic               vld_o,
    output logic [width_p-1:0] data_o
);
    // Data only moves with a valid item so a bubble never overwrites held data.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            vld_o  <= 1'b0;
            data_o <= '0;
        end else if (flush_i) begin
            vld_o <= 1'b0;
        end else if (adv_i) begin
            vld_o <= vld_i;
            if (vld_i) data_o <= data_i;
        end
    end
endmodule

module pipe_elastic #(
    parameter int width_p = 8,
    parameter int depth_p = 3
) (
    input  logic          clk_i,
    input  logic          reset_ni,
    pipe_elastic_if.slave bus
);
    localparam int cnt_w_lp = $clog2(depth_p + 1);

    if (width_p < 1) begin : g_bad_width
        $error("pipe_elastic: width_p must be >= 1");
    end
    if (depth_p < 1) begin : g_bad_depth
        $error("pipe_elastic: depth_p must be >= 1");
    end

    logic [depth_p-1:0]              valid_r;
    logic [depth_p-1:0][width_p-1:0] data_r;
    logic [depth_p-1:0]              adv;
    logic [cnt_w_lp-1:0]             count_r;
    logic                            in_xfer, out_xfer;

    // A stage may advance if the one below advances or it is itself empty.
    always_comb begin
        adv = '0;
        adv[depth_p-1] = bus.ready_i | ~valid_r[depth_p-1];
        for (int k = depth_p - 2; k >= 0; k--) begin
            adv[k] = adv[k+1] | ~valid_r[k];
        end
    end

    for (genvar k = 0; k < depth_p; k++) begin : g_stage
        logic               src_vld;
        logic [width_p-1:0] src_data;
        if (k == 0) begin : g_head
            assign src_vld  = bus.valid_i;
            assign src_data = bus.data_i;
        end else begin : g_body
            assign src_vld  = valid_r[k-1];
            assign src_data = data_r[k-1];
        end
        pipe_elastic_stage #(.width_p(width_p)) u_stage (
            .clk_i    (clk_i),
            .reset_ni (reset_ni),
            .flush_i  (bus.flush_i),
            .adv_i    (adv[k]),
            .vld_i    (src_vld),
            .data_i   (src_data),
            .vld_o    (valid_r[k]),
            .data_o   (data_r[k])
        );
    end

    assign bus.ready_o = adv[0] & ~bus.flush_i;
    assign bus.valid_o = valid_r[depth_p-1] & ~bus.flush_i;
    assign bus.data_o  = data_r[depth_p-1];
    assign bus.count_o = count_r;

    assign in_xfer  = bus.valid_i & bus.ready_o;
    assign out_xfer = bus.valid_o & bus.ready_i;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni)               count_r <= '0;
        else if (bus.flush_i)        count_r <= '0;
        else if (in_xfer & ~out_xfer) count_r <= count_r + 1'b1;
        else if (~in_xfer & out_xfer) count_r <= count_r - 1'b1;
    end

    a_count_matches: assert property (@(posedge clk_i) disable iff (!reset_ni)
        32'(count_r) == $countones(valid_r));
endmodule

// File: doc/pipe_elastic.md
Name: pipe_elastic

Overview:
Parametrised elastic pipeline register: a chain of depth_p stages, each width_p bits wide, with valid/ready handshakes on both ends. It generalises the single enabled flip-flop into a multi-stage, back-pressurable delay line. Bubbles collapse: an empty stage always accepts data, even while the output is stalled. It also supports a synchronous flush and reports its occupancy. It sits between producer and consumer blocks that need registered timing isolation plus a small amount of buffering.

Parameters:
width_p, 8, data width in bits; must be >= 1 (elaboration error otherwise)
depth_p, 3, number of register stages; must be >= 1 (elaboration error otherwise)

Ports:
clk_i  input  1  clock; all state updates on posedge
reset_ni  input  1  asynchronous active-low reset
valid_i  input  1  producer has data on data_i
data_i  input  width_p  input data
ready_o  output  1  pipeline accepts data_i this cycle
valid_o  output  1  data_o holds a valid item
data_o  output  width_p  output data (contents of last stage)
ready_i  input  1  consumer accepts data_o this cycle
flush_i  input  1  synchronous flush; discards all held items
count_o  output  $clog2(depth_p+1)  number of valid stages

Behaviour:
- State per stage k (0 = input side, depth_p-1 = output side): valid_r[k] (1 bit), data_r[k] (width_p bits).
- Reset (reset_ni low): asynchronous, takes effect with no clock edge.
  - All valid_r = 0; all data_r = 0.
  - Therefore valid_o = 0, data_o = 0, count_o = 0, and ready_o = 1 (unless flush_i is high).
  - Reset asserted mid-stream discards all items immediately.
- Advance chain (combinational):
  - adv[depth_p-1] = ready_i | ~valid_r[depth_p-1].
  - adv[k] = adv[k+1] | ~valid_r[k].
  - A stage loads from its upstream source when adv[k] is 1. The source is data_i/valid_i for stage 0, and stage k-1 otherwise.
- Handshake outputs:
  - ready_o = adv[0] & ~flush_i.
  - valid_o = valid_r[depth_p-1] & ~flush_i.
  - data_o = data_r[depth_p-1] at all times; data is not gated by valid.
- Transfers: input accepted iff valid_i & ready_o; output consumed iff valid_o & ready_i. No transfer of either kind occurs in a flush cycle.
- Data capture: data_r[k] updates only when adv[k] = 1 and the incoming valid is 1. The last value is held otherwise.
- Flush (flush_i high at posedge, reset_ni high): all valid_r cleared and data_r unchanged. count_o = 0 the following cycle. valid_i asserted during the flush cycle is not accepted.
- Latency and throughput:
  - With ready_i held at 1, an item accepted at edge N is presented on valid_o/data_o after edge N+depth_p-1. That is depth_p cycles from valid_i to valid_o, with valid_o first visible in cycle N+depth_p.
  - Sustained throughput is 1 item per cycle. Ordering is strictly FIFO; no item is duplicated or dropped.
- Back-pressure:
  - When ready_i = 0, items collapse toward the output until all depth_p stages are valid. ready_o then drops to 0 combinationally.
  - ready_o rises in the same cycle that ready_i rises, since the chain is combinational.
- Simultaneous push and pop: when full, if ready_i = 1 and valid_i = 1 in the same cycle, both transfer. count_o is unchanged.
- count_o:
  - Registered, and updated each edge: +1 on input transfer only, -1 on output transfer only, unchanged on both or neither, and 0 on flush or reset.
  - Never exceeds depth_p and never underflows.
  - Must equal the popcount of valid_r at all times (checker assertion).

Test Plan:
All scenarios use width_p=8, depth_p=3.
1. Reset: assert reset_ni=0 mid-cycle while 2 items are held. valid_o=0, data_o=0x00 and count_o=0 immediately, with no clock edge. After release, ready_o=1.
2. Streaming: ready_i=1, push 0x01..0x0A on consecutive cycles. 0x01 appears on valid_o 3 cycles after acceptance, then 0x02..0x0A on consecutive cycles with no gaps. count_o holds 3 during steady state.
3. Back-pressure: ready_i=0, valid_i=1 with 0x11,0x22,0x33,0x44.
   - 0x11..0x33 are accepted; ready_o=0 while 0x44 is held; count_o=3.
   - Raise ready_i: 0x11 pops and ready_o=1 in the same cycle; 0x44 is accepted.
   - Drain order is 0x11,0x22,0x33,0x44.
4. Bubble collapse: ready_i=0, push 0xA5, idle 2 cycles, push 0x5A. After 2 more cycles, valid_r=3'b110 (stages 1 and 2), count_o=2, ready_o=1.
5. Flush: pipeline full (0x01,0x02,0x03), flush_i=1 for one cycle with valid_i=1 and data_i=0xFF.
   - That cycle: valid_o=0 and ready_o=0.
   - Next cycle: count_o=0 and valid_o=0.
   - 0xFF, still driven, is accepted on the following edge and emerges 3 cycles later.
6. Full push and pop: full with ready_i=1 and valid_i=1 for 5 cycles. count_o stays 3, and output order matches input order.
